// File: rtl/axi_lite_clkdiv_slave_if.sv
// AXI4-Lite bus bundle for the clock-divider register slave.
interface axi_lite_clkdiv_slave_if #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
);
  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR;
  logic [2:0]                      S_AXI_AWPROT;
  logic                            S_AXI_AWVALID;
  logic                            S_AXI_AWREADY;
  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA;
  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB;
  logic                            S_AXI_WVALID;
  logic                            S_AXI_WREADY;
  logic [1:0]                      S_AXI_BRESP;
  logic                            S_AXI_BVALID;
  logic                            S_AXI_BREADY;
  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR;
  logic [2:0]                      S_AXI_ARPROT;
  logic                            S_AXI_ARVALID;
  logic                            S_AXI_ARREADY;
  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA;
  logic [1:0]                      S_AXI_RRESP;
  logic                            S_AXI_RVALID;
  logic                            S_AXI_RREADY;

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    output S_AXI_AWREADY,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    output S_AXI_WREADY,
    output S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_BREADY,
    input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    output S_AXI_ARREADY,
    output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    input  S_AXI_RREADY
  );

  modport master (
    output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    input  S_AXI_AWREADY,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    input  S_AXI_WREADY,
    input  S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_BREADY,
    output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    input  S_AXI_ARREADY,
    input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    output S_AXI_RREADY
  );
endinterface

// File: rtl/axi_lite_clkdiv_slave.sv
// AXI4-Lite slave with CTRL/DIV/SCRATCH/STATUS registers driving a
// programmable 50%-duty divided clock level and a rising-edge tick.
module axi_lite_clkdiv_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int C_DIV_WIDTH        = 16
) (
  input  logic                      ACLK,
  input  logic                      ARESET,
  axi_lite_clkdiv_slave_if.slave    s_axi,
  output logic                      clk_div_out,
  output logic                      div_tick
);

  localparam int STRB_W = C_S_AXI_DATA_WIDTH / 8;
  localparam logic [C_DIV_WIDTH-1:0] CNT_ONE = C_DIV_WIDTH'(1);

  logic                          rst_done_q, rst_done_d;
  logic                          aw_full_q, aw_full_d;
  logic [C_S_AXI_ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
  logic                          w_full_q, w_full_d;
  logic [31:0]                   w_data_q, w_data_d;
  logic [STRB_W-1:0]             w_strb_q, w_strb_d;
  logic                          bvalid_q, bvalid_d;
  logic                          rvalid_q, rvalid_d;
  logic [31:0]                   rdata_q, rdata_d;
  logic                          en_q, en_d;
  logic [C_DIV_WIDTH-1:0]        div_q, div_d;
  logic [31:0]                   scratch_q, scratch_d;
  logic [C_DIV_WIDTH-1:0]        cnt_q, cnt_d;
  logic                          clk_q, clk_d;
  logic [15:0]                   edge_cnt_q, edge_cnt_d;
  logic                          tick_q, tick_d;

  logic        awready, wready, arready;
  logic        aw_hs, w_hs, ar_hs, do_wr, clr;
  logic [31:0] rd_word;
  logic        unused_bits;

  // Byte-lane merge of new write data over an existing register value.
  function automatic logic [31:0] lane_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  strb);
    logic [31:0] r;
    r = old_v;
    for (int unsigned b = 0; b < 4; b++) begin
      if (strb[b]) r[8*b +: 8] = new_v[8*b +: 8];
    end
    return r;
  endfunction

  assign awready = rst_done_q && !aw_full_q && !bvalid_q;
  assign wready  = rst_done_q && !w_full_q && !bvalid_q;
  assign arready = rst_done_q && !rvalid_q;

  assign s_axi.S_AXI_AWREADY = awready;
  assign s_axi.S_AXI_WREADY  = wready;
  assign s_axi.S_AXI_BVALID  = bvalid_q;
  assign s_axi.S_AXI_BRESP   = 2'b00;
  assign s_axi.S_AXI_ARREADY = arready;
  assign s_axi.S_AXI_RVALID  = rvalid_q;
  assign s_axi.S_AXI_RDATA   = rdata_q;
  assign s_axi.S_AXI_RRESP   = 2'b00;
  assign clk_div_out         = clk_q;
  assign div_tick            = tick_q;

  assign unused_bits = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                         s_axi.S_AXI_ARADDR, aw_addr_q};

  // Next-state for write holdings, register bank, divider and read path.
  always_comb begin
    rst_done_d = 1'b1;
    aw_hs      = s_axi.S_AXI_AWVALID && awready;
    w_hs       = s_axi.S_AXI_WVALID && wready;
    ar_hs      = s_axi.S_AXI_ARVALID && arready;
    do_wr      = aw_full_q && w_full_q;

    aw_full_d = aw_full_q;
    aw_addr_d = aw_addr_q;
    w_full_d  = w_full_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    if (do_wr) begin
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
    end else begin
      if (aw_hs) begin
        aw_full_d = 1'b1;
        aw_addr_d = s_axi.S_AXI_AWADDR;
      end
      if (w_hs) begin
        w_full_d = 1'b1;
        w_data_d = s_axi.S_AXI_WDATA;
        w_strb_d = s_axi.S_AXI_WSTRB;
      end
    end

    bvalid_d = bvalid_q;
    if (do_wr) bvalid_d = 1'b1;
    else if (bvalid_q && s_axi.S_AXI_BREADY) bvalid_d = 1'b0;

    en_d      = en_q;
    div_d     = div_q;
    scratch_d = scratch_q;
    clr       = 1'b0;
    if (do_wr) begin
      case (aw_addr_q[3:2])
        2'd0: if (w_strb_q[0]) begin
          en_d = w_data_q[0];
          clr  = w_data_q[1];
        end
        2'd1: div_d = C_DIV_WIDTH'(lane_merge(32'(div_q), w_data_q, w_strb_q));
        2'd2: scratch_d = lane_merge(scratch_q, w_data_q, w_strb_q);
        default: ;
      endcase
    end

    cnt_d      = cnt_q;
    clk_d      = clk_q;
    edge_cnt_d = edge_cnt_q;
    tick_d     = 1'b0;
    if (clr) begin
      cnt_d      = '0;
      clk_d      = 1'b0;
      edge_cnt_d = '0;
    end else if (en_q) begin
      if (cnt_q >= div_q) begin
        cnt_d = '0;
        clk_d = !clk_q;
        if (!clk_q) begin
          tick_d     = 1'b1;
          edge_cnt_d = edge_cnt_q + 16'd1;
        end
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end

    rd_word = '0;
    case (s_axi.S_AXI_ARADDR[3:2])
      2'd0: rd_word = {31'd0, en_q};
      2'd1: rd_word = 32'(div_q);
      2'd2: rd_word = scratch_q;
      default: rd_word = {clk_q, 15'd0, edge_cnt_q};
    endcase

    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_word;
    end else if (rvalid_q && s_axi.S_AXI_RREADY) begin
      rvalid_d = 1'b0;
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      rst_done_q <= 1'b0;
      aw_full_q  <= 1'b0;
      aw_addr_q  <= '0;
      w_full_q   <= 1'b0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      bvalid_q   <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      en_q       <= 1'b0;
      div_q      <= '0;
      scratch_q  <= '0;
      cnt_q      <= '0;
      clk_q      <= 1'b0;
      edge_cnt_q <= '0;
      tick_q     <= 1'b0;
    end else begin
      rst_done_q <= rst_done_d;
      aw_full_q  <= aw_full_d;
      aw_addr_q  <= aw_addr_d;
      w_full_q   <= w_full_d;
      w_data_q   <= w_data_d;
      w_strb_q   <= w_strb_d;
      bvalid_q   <= bvalid_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      en_q       <= en_d;
      div_q      <= div_d;
      scratch_q  <= scratch_d;
      cnt_q      <= cnt_d;
      clk_q      <= clk_d;
      edge_cnt_q <= edge_cnt_d;
      tick_q     <= tick_d;
    end
  end

endmodule

// File: tb/tb_axi_lite_clkdiv_slave.sv
// Self-checking bench for axi_lite_clkdiv_slave: scoreboarded reads and
// write responses, closed-form divider monitor.
`timescale 1ns/1ps
module tb_axi_lite_clkdiv_slave;

  logic ACLK = 1'b0;
  logic ARESET;
  logic clk_div_out, div_tick;

  axi_lite_clkdiv_slave_if #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4)) bus ();

  axi_lite_clkdiv_slave #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(4),
    .C_DIV_WIDTH(16)
  ) dut (
    .ACLK(ACLK),
    .ARESET(ARESET),
    .s_axi(bus.slave),
    .clk_div_out(clk_div_out),
    .div_tick(div_tick)
  );

  always #5 ACLK = ~ACLK;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge ACLK) cyc <= cyc + 1;

  logic [31:0] rd_exp_q[$];
  logic [1:0]  b_exp_q[$];

  // Divider monitor: k cycles after the CTRL write that set EN.
  bit mon_en   = 1'b0;
  int mon_base = 0;
  int mon_div  = 0;

  function automatic logic exp_clk(input int k, input int d);
    return ((k / (d + 1)) % 2) == 1;
  endfunction

  function automatic logic exp_tick(input int k, input int d);
    return (k > 0) && ((k % (2 * (d + 1))) == (d + 1));
  endfunction

  function automatic logic [31:0] exp_status(input int k, input int d);
    int n;
    n = (k >= d + 1) ? ((k - (d + 1)) / (2 * (d + 1)) + 1) : 0;
    return {exp_clk(k, d), 15'd0, 16'(n)};
  endfunction

  always @(negedge ACLK) begin
    int k;
    if (mon_en) begin
      k = cyc - mon_base;
      checks++;
      if (clk_div_out !== exp_clk(k, mon_div)) begin
        errors++;
        $display("FAIL clk_div_out k=%0d got %b exp %b", k, clk_div_out, exp_clk(k, mon_div));
      end
      checks++;
      if (div_tick !== exp_tick(k, mon_div)) begin
        errors++;
        $display("FAIL div_tick k=%0d got %b exp %b", k, div_tick, exp_tick(k, mon_div));
      end
    end
  end

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
    bit awd, wd;
    int n;
    logic [1:0] e;
    awd = 1'b0;
    wd  = 1'b0;
    b_exp_q.push_back(2'b00);
    bus.S_AXI_AWADDR  = addr;
    bus.S_AXI_AWVALID = 1'b1;
    bus.S_AXI_WDATA   = data;
    bus.S_AXI_WSTRB   = strb;
    bus.S_AXI_WVALID  = 1'b1;
    n = 0;
    while (!(awd && wd) && n < 50) begin
      if (bus.S_AXI_AWVALID && bus.S_AXI_AWREADY) awd = 1'b1;
      if (bus.S_AXI_WVALID && bus.S_AXI_WREADY) wd = 1'b1;
      step();
      n++;
      if (awd) bus.S_AXI_AWVALID = 1'b0;
      if (wd) bus.S_AXI_WVALID = 1'b0;
    end
    bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WVALID  = 1'b0;
    bus.S_AXI_BREADY  = 1'b1;
    n = 0;
    while (!bus.S_AXI_BVALID && n < 50) begin
      step();
      n++;
    end
    checks++;
    e = b_exp_q.pop_front();
    if (!bus.S_AXI_BVALID) begin
      errors++;
      $display("FAIL write_b_timeout addr=%h got BVALID=0 exp 1", addr);
    end else begin
      if (addr == 4'h0 && strb[0]) begin
        mon_base = cyc;
        mon_en   = data[0];
      end
      if (addr == 4'h4 && strb == 4'hF) mon_div = int'(data[15:0]);
      if (bus.S_AXI_BRESP !== e) begin
        errors++;
        $display("FAIL bresp addr=%h got %b exp %b", addr, bus.S_AXI_BRESP, e);
      end
    end
    step();
    bus.S_AXI_BREADY = 1'b0;
  endtask

  task automatic axi_read(input logic [3:0] addr, input logic [31:0] exp_v);
    int n;
    logic [31:0] e;
    rd_exp_q.push_back(exp_v);
    bus.S_AXI_ARADDR  = addr;
    bus.S_AXI_ARVALID = 1'b1;
    n = 0;
    while (!bus.S_AXI_ARREADY && n < 50) begin
      step();
      n++;
    end
    step();
    bus.S_AXI_ARVALID = 1'b0;
    bus.S_AXI_RREADY  = 1'b1;
    n = 0;
    while (!bus.S_AXI_RVALID && n < 50) begin
      step();
      n++;
    end
    e = rd_exp_q.pop_front();
    checks++;
    if (!bus.S_AXI_RVALID) begin
      errors++;
      $display("FAIL read_timeout addr=%h got RVALID=0 exp 1", addr);
    end else begin
      if (bus.S_AXI_RDATA !== e) begin
        errors++;
        $display("FAIL rdata addr=%h got %h exp %h", addr, bus.S_AXI_RDATA, e);
      end
      checks++;
      if (bus.S_AXI_RRESP !== 2'b00) begin
        errors++;
        $display("FAIL rresp addr=%h got %b exp 00", addr, bus.S_AXI_RRESP);
      end
    end
    step();
    bus.S_AXI_RREADY = 1'b0;
  endtask

  task automatic wait_k(input int k);
    int n;
    n = 0;
    while ((cyc - mon_base) < k && n < 1000) begin
      step();
      n++;
    end
  endtask

  task automatic test_reset();
    ARESET = 1'b1;
    bus.S_AXI_AWADDR = '0; bus.S_AXI_AWPROT = '0; bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WDATA = '0;  bus.S_AXI_WSTRB = '0;  bus.S_AXI_WVALID = 1'b0;
    bus.S_AXI_BREADY = 1'b0;
    bus.S_AXI_ARADDR = '0; bus.S_AXI_ARPROT = '0; bus.S_AXI_ARVALID = 1'b0;
    bus.S_AXI_RREADY = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if ({bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY, bus.S_AXI_BVALID,
           bus.S_AXI_RVALID, clk_div_out, div_tick} !== 7'd0 ||
          bus.S_AXI_RDATA !== 32'd0 || bus.S_AXI_BRESP !== 2'd0 || bus.S_AXI_RRESP !== 2'd0) begin
        errors++;
        $display("FAIL reset_outputs cycle=%0d got rdy/valid/div=%b rdata=%h exp all zero", i,
                 {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY, bus.S_AXI_BVALID,
                  bus.S_AXI_RVALID, clk_div_out, div_tick}, bus.S_AXI_RDATA);
      end
    end
    ARESET = 1'b0;
    checks++;
    if ({bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY} !== 3'b000) begin
      errors++;
      $display("FAIL ready_before_edge got %b exp 000",
               {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY});
    end
    step();
    checks++;
    if ({bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY} !== 3'b111) begin
      errors++;
      $display("FAIL ready_after_reset got %b exp 111",
               {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY});
    end
    axi_read(4'h0, 32'h0);
    axi_read(4'h4, 32'h0);
    axi_read(4'h8, 32'h0);
    axi_read(4'hC, 32'h0);
  endtask

  task automatic test_regs();
    axi_write(4'hC, 32'h4, 4'hF);
    axi_read(4'hC, 32'h0);
    axi_write(4'h4, 32'h2, 4'hF);
    axi_write(4'h0, 32'h1, 4'hF);
    axi_write(4'h8, 32'h3, 4'hF);
    axi_read(4'h0, 32'h1);
    axi_read(4'h4, 32'h2);
    axi_read(4'h8, 32'h3);
    axi_write(4'h0, 32'h2, 4'hF);
    axi_read(4'hC, 32'h0);
    axi_read(4'h0, 32'h0);
  endtask

  task automatic test_divider();
    axi_write(4'h0, 32'h1, 4'hF);
    wait_k(62);
    axi_read(4'hC, exp_status(cyc - mon_base, mon_div));
  endtask

  task automatic test_clr();
    axi_write(4'h0, 32'h3, 4'hF);
    axi_read(4'hC, exp_status(cyc - mon_base, mon_div));
    axi_read(4'h0, 32'h1);
    wait_k(20);
    axi_read(4'hC, exp_status(cyc - mon_base, mon_div));
    axi_write(4'h0, 32'h0, 4'hF);
  endtask

  task automatic test_backpressure();
    int n;
    logic [1:0] e;
    bus.S_AXI_BREADY  = 1'b0;
    bus.S_AXI_AWADDR  = 4'h8;
    bus.S_AXI_AWVALID = 1'b1;
    checks++;
    if (bus.S_AXI_AWREADY !== 1'b1) begin
      errors++;
      $display("FAIL bp_awready_idle got %b exp 1", bus.S_AXI_AWREADY);
    end
    step();
    bus.S_AXI_AWVALID = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({bus.S_AXI_AWREADY, bus.S_AXI_WREADY} !== 2'b01) begin
        errors++;
        $display("FAIL bp_aw_held got aw/w ready %b exp 01", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY});
      end
      step();
    end
    bus.S_AXI_WDATA  = 32'h55AA55AA;
    bus.S_AXI_WSTRB  = 4'hF;
    bus.S_AXI_WVALID = 1'b1;
    step();
    bus.S_AXI_WVALID = 1'b0;
    b_exp_q.push_back(2'b00);
    n = 0;
    while (!bus.S_AXI_BVALID && n < 10) begin
      step();
      n++;
    end
    checks++;
    if (bus.S_AXI_BVALID !== 1'b1) begin
      errors++;
      $display("FAIL bp_bvalid got %b exp 1", bus.S_AXI_BVALID);
    end
    bus.S_AXI_AWADDR  = 4'h8;
    bus.S_AXI_WDATA   = 32'h12345678;
    bus.S_AXI_AWVALID = 1'b1;
    bus.S_AXI_WVALID  = 1'b1;
    axi_read(4'h8, 32'h55AA55AA);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({bus.S_AXI_BVALID, bus.S_AXI_AWREADY, bus.S_AXI_WREADY} !== 3'b100) begin
        errors++;
        $display("FAIL bp_stall got bvalid/awready/wready %b exp 100",
                 {bus.S_AXI_BVALID, bus.S_AXI_AWREADY, bus.S_AXI_WREADY});
      end
      step();
    end
    bus.S_AXI_BREADY = 1'b1;
    e = b_exp_q.pop_front();
    checks++;
    if (bus.S_AXI_BRESP !== e) begin
      errors++;
      $display("FAIL bp_bresp got %b exp %b", bus.S_AXI_BRESP, e);
    end
    step();
    bus.S_AXI_BREADY = 1'b0;
    checks++;
    if ({bus.S_AXI_BVALID, bus.S_AXI_AWREADY, bus.S_AXI_WREADY} !== 3'b011) begin
      errors++;
      $display("FAIL bp_release got bvalid/awready/wready %b exp 011",
               {bus.S_AXI_BVALID, bus.S_AXI_AWREADY, bus.S_AXI_WREADY});
    end
    axi_write(4'h8, 32'h12345678, 4'hF);
    axi_read(4'h8, 32'h12345678);
  endtask

  task automatic test_wstrb();
    axi_write(4'h8, 32'h11223344, 4'hF);
    axi_write(4'h8, 32'hAABBCCDD, 4'b0010);
    axi_read(4'h8, 32'h1122CC44);
    axi_write(4'h4, 32'hFFFF_0000, 4'b0100);
    axi_read(4'h4, 32'h0000_0002);
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    for (int i = 0; i < 6; i++) begin
      d = $urandom;
      axi_write(4'h8, d, 4'hF);
      axi_read(4'h8, d);
      d = $urandom;
      axi_write(4'h4, d, 4'hF);
      axi_read(4'h4, {16'h0, d[15:0]});
    end
  endtask

  task automatic test_div0();
    axi_write(4'h4, 32'h0, 4'hF);
    axi_write(4'h0, 32'h3, 4'hF);
    wait_k(15);
    axi_read(4'hC, exp_status(cyc - mon_base, mon_div));
    axi_write(4'h0, 32'h2, 4'hF);
    axi_read(4'hC, 32'h0);
  endtask

  initial begin
    test_reset();
    test_regs();
    test_divider();
    test_clr();
    test_backpressure();
    test_wstrb();
    test_back_to_back();
    test_div0();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
